// File: rtl/s_array_check.sv
// S-array read-back checker: sweeps every RAM location once and verifies either
// the identity pattern left by the initializer or the permutation left by the KSA.
module s_array_check #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  perm_mode,
    output logic [ADDR_WIDTH-1:0] array_address,
    input  logic [DATA_WIDTH-1:0] q,
    output logic                  write_enable,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   error_count,
    output logic [ADDR_WIDTH-1:0] first_bad_addr,
    output logic                  first_bad_valid
);

    localparam int SEEN_DEPTH = 1 << DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t                  state;
    logic                    mode;
    logic                    rd_valid;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [SEEN_DEPTH-1:0]   seen;
    logic                    cmp_fail;
    logic [ADDR_WIDTH:0]     err_next;

    // rd_valid/rd_addr describe the word currently on q (address registered by the RAM last edge).
    always_comb begin
        cmp_fail = 1'b0;
        if (rd_valid) begin
            if (mode) begin
                cmp_fail = seen[q];
            end else begin
                cmp_fail = (q != DATA_WIDTH'(rd_addr));
            end
        end
        err_next = error_count + {{ADDR_WIDTH{1'b0}}, cmp_fail};
    end

    assign write_enable = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            mode            <= 1'b0;
            rd_valid        <= 1'b0;
            rd_addr         <= '0;
            seen            <= '0;
            array_address   <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            error_count     <= '0;
            first_bad_addr  <= '0;
            first_bad_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;

            if (rd_valid) begin
                error_count <= err_next;
                if (cmp_fail && !first_bad_valid) begin
                    first_bad_addr  <= rd_addr;
                    first_bad_valid <= 1'b1;
                end
                if (mode) begin
                    seen[q] <= 1'b1;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mode            <= perm_mode;
                        error_count     <= '0;
                        first_bad_addr  <= '0;
                        first_bad_valid <= 1'b0;
                        pass            <= 1'b0;
                        seen            <= '0;
                        array_address   <= '0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        state           <= READ;
                    end
                end
                READ: begin
                    rd_valid <= 1'b1;
                    rd_addr  <= array_address;
                    if (array_address == ADDR_MAX) begin
                        state <= DRAIN;
                    end else begin
                        array_address <= array_address + 1'b1;
                    end
                end
                DRAIN: begin
                    // The last word is compared on this edge, so pass must use the updated count.
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_next == '0);
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s_array_check.sv
// Self-checking bench for s_array_check: synchronous-read RAM model, scenario tasks,
// and a loop-based reference model of the expected error results.
module tb_s_array_check;

    logic       clk;
    logic       reset;
    logic       start;
    logic       perm_mode;
    logic [7:0] array_address;
    logic [7:0] q;
    logic       write_enable;
    logic       busy;
    logic       done;
    logic       pass;
    logic [8:0] error_count;
    logic [7:0] first_bad_addr;
    logic       first_bad_valid;

    int checks = 0;
    int errors = 0;
    int we_bad = 0;

    logic [7:0] mem [256];

    s_array_check #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .perm_mode      (perm_mode),
        .array_address  (array_address),
        .q              (q),
        .write_enable   (write_enable),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .error_count    (error_count),
        .first_bad_addr (first_bad_addr),
        .first_bad_valid(first_bad_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) q <= mem[array_address];

    always @(negedge clk) if (write_enable !== 1'b0) we_bad++;

    // Reference: identity fails where S[i]!=i; permutation fails where the value occurred earlier.
    task automatic model(input bit mode, output int errs, output int first, output bit fvalid);
        errs = 0;
        first = 0;
        fvalid = 0;
        for (int i = 0; i < 256; i++) begin
            bit bad;
            bad = 0;
            if (mode) begin
                for (int j = 0; j < i; j++) if (mem[j] == mem[i]) bad = 1;
            end else begin
                bad = (int'(mem[i]) != i);
            end
            if (bad) begin
                errs++;
                if (!fvalid) begin
                    first = i;
                    fvalid = 1;
                end
            end
        end
    endtask

    task automatic load_identity();
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    endtask

    task automatic load_ksa();
        logic [7:0] key [3];
        logic [7:0] j;
        logic [7:0] t;
        key[0] = 8'h00; key[1] = 8'h00; key[2] = 8'h01;
        load_identity();
        j = 8'h00;
        for (int i = 0; i < 256; i++) begin
            j = j + mem[i] + key[i % 3];
            t = mem[i];
            mem[i] = mem[j];
            mem[j] = t;
        end
    endtask

    task automatic load_random_perm();
        logic [7:0] t;
        int k;
        load_identity();
        for (int i = 255; i > 0; i--) begin
            k = int'($urandom_range(i, 0));
            t = mem[i];
            mem[i] = mem[k];
            mem[k] = t;
        end
    endtask

    task automatic run_sweep(input bit mode, output int cycles);
        @(negedge clk);
        perm_mode = mode;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cycles = -1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        perm_mode = 1'b0;
        load_identity();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, pass, first_bad_valid} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags busy/done/pass/fbv=%b required 0000", {busy, done, pass, first_bad_valid});
        end
        checks++;
        if (array_address !== 8'h00 || error_count !== 9'd0 || first_bad_addr !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_values addr=%h cnt=%0d fba=%h required 0/0/0", array_address, error_count, first_bad_addr);
        end
        @(negedge clk) reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || array_address !== 8'h00) begin
            errors++;
            $display("[TB] FAIL idle_after_reset busy=%b addr=%h required 0/00", busy, array_address);
        end
    endtask

    task automatic test_identity_clean();
        int cyc;
        load_identity();
        run_sweep(1'b0, cyc);
        checks++;
        if (cyc != 257) begin
            errors++;
            $display("[TB] FAIL ident_latency got %0d required 257", cyc);
        end
        checks++;
        if (pass !== 1'b1 || error_count !== 9'd0 || first_bad_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ident_clean pass=%b cnt=%0d fbv=%b required 1/0/0", pass, error_count, first_bad_valid);
        end
        checks++;
        if (array_address !== 8'hFF || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ident_end addr=%h busy=%b required ff/0", array_address, busy);
        end
    endtask

    task automatic test_identity_errors();
        int cyc;
        load_identity();
        mem[8'h10] = 8'h11;
        mem[8'h80] = 8'h00;
        run_sweep(1'b0, cyc);
        checks++;
        if (cyc != 257) begin
            errors++;
            $display("[TB] FAIL ident_err_latency got %0d required 257", cyc);
        end
        checks++;
        if (pass !== 1'b0 || error_count !== 9'd2) begin
            errors++;
            $display("[TB] FAIL ident_err_count pass=%b cnt=%0d required 0/2", pass, error_count);
        end
        checks++;
        if (first_bad_valid !== 1'b1 || first_bad_addr !== 8'h10) begin
            errors++;
            $display("[TB] FAIL ident_err_first fbv=%b fba=%h required 1/10", first_bad_valid, first_bad_addr);
        end
    endtask

    task automatic test_ksa_perm();
        int cyc, e_errs, e_first;
        bit e_fv;
        load_ksa();
        run_sweep(1'b1, cyc);
        checks++;
        if (cyc != 257 || pass !== 1'b1 || error_count !== 9'd0 || first_bad_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ksa_perm cyc=%0d pass=%b cnt=%0d fbv=%b required 257/1/0/0", cyc, pass, error_count, first_bad_valid);
        end
        model(1'b0, e_errs, e_first, e_fv);
        run_sweep(1'b0, cyc);
        checks++;
        if (pass !== 1'b0 || error_count == 9'd0 || int'(error_count) != e_errs) begin
            errors++;
            $display("[TB] FAIL ksa_ident pass=%b cnt=%0d required 0/%0d", pass, error_count, e_errs);
        end
        checks++;
        if (first_bad_valid !== e_fv || int'(first_bad_addr) != e_first) begin
            errors++;
            $display("[TB] FAIL ksa_ident_first fbv=%b fba=%h required %b/%h", first_bad_valid, first_bad_addr, e_fv, e_first);
        end
    endtask

    task automatic test_perm_duplicate();
        int cyc;
        logic [7:0] t;
        load_ksa();
        for (int k = 0; k < 256; k++) begin
            if (mem[k] == 8'h2A) begin
                t = mem[3];
                mem[3] = mem[k];
                mem[k] = t;
                break;
            end
        end
        mem[8'h05] = 8'h2A;
        run_sweep(1'b1, cyc);
        checks++;
        if (pass !== 1'b0 || error_count !== 9'd1) begin
            errors++;
            $display("[TB] FAIL perm_dup_count pass=%b cnt=%0d required 0/1", pass, error_count);
        end
        checks++;
        if (first_bad_valid !== 1'b1 || first_bad_addr !== 8'h05) begin
            errors++;
            $display("[TB] FAIL perm_dup_first fbv=%b fba=%h required 1/05", first_bad_valid, first_bad_addr);
        end
    endtask

    task automatic test_start_ignored_and_restart();
        int cyc;
        load_identity();
        mem[8'h20] = 8'h00;
        @(negedge clk);
        perm_mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = -1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            if (k == 99) start = 1'b1;
            if (k == 100) start = 1'b0;
            if (done) begin
                cyc = k;
                break;
            end
        end
        checks++;
        if (cyc != 257 || error_count !== 9'd1 || first_bad_addr !== 8'h20) begin
            errors++;
            $display("[TB] FAIL start_ignored cyc=%0d cnt=%0d fba=%h required 257/1/20", cyc, error_count, first_bad_addr);
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || error_count !== 9'd0 || first_bad_valid !== 1'b0 || pass !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_clear done=%b busy=%b cnt=%0d fbv=%b pass=%b required 0/1/0/0/0",
                     done, busy, error_count, first_bad_valid, pass);
        end
        cyc = -1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = k;
                break;
            end
        end
        checks++;
        if (cyc != 257 || error_count !== 9'd1) begin
            errors++;
            $display("[TB] FAIL restart_sweep cyc=%0d cnt=%0d required 257/1", cyc, error_count);
        end
    endtask

    task automatic test_reset_mid_sweep();
        load_identity();
        mem[8'h01] = 8'h07;
        mem[8'h02] = 8'h07;
        @(negedge clk);
        perm_mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (50) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || array_address !== 8'h00 || error_count !== 9'd0) begin
            errors++;
            $display("[TB] FAIL async_reset busy=%b done=%b addr=%h cnt=%0d required 0/0/00/0",
                     busy, done, array_address, error_count);
        end
        @(negedge clk) reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || array_address !== 8'h00 || first_bad_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle busy=%b done=%b addr=%h fbv=%b required 0/0/00/0",
                     busy, done, array_address, first_bad_valid);
        end
    endtask

    task automatic test_random();
        int cyc, e_errs, e_first, n_bad;
        bit e_fv, mode;
        for (int it = 0; it < 6; it++) begin
            load_random_perm();
            n_bad = int'($urandom_range(3, 0));
            for (int b = 0; b < n_bad; b++) mem[$urandom_range(255, 0)] = 8'($urandom);
            mode = (it % 2 == 1) ? 1'b1 : 1'($urandom);
            if (it == 0) load_identity();
            model(mode, e_errs, e_first, e_fv);
            run_sweep(mode, cyc);
            checks++;
            if (cyc != 257 || int'(error_count) != e_errs || pass !== (e_errs == 0)) begin
                errors++;
                $display("[TB] FAIL random_count it=%0d mode=%b cyc=%0d cnt=%0d pass=%b required 257/%0d/%b",
                         it, mode, cyc, error_count, pass, e_errs, (e_errs == 0));
            end
            checks++;
            if (first_bad_valid !== e_fv || (e_fv && int'(first_bad_addr) != e_first)) begin
                errors++;
                $display("[TB] FAIL random_first it=%0d fbv=%b fba=%h required %b/%h",
                         it, first_bad_valid, first_bad_addr, e_fv, e_first);
            end
        end
    endtask

    task automatic test_write_enable();
        checks++;
        if (we_bad != 0) begin
            errors++;
            $display("[TB] FAIL write_enable asserted_cycles=%0d required 0", we_bad);
        end
    endtask

    initial begin
        test_reset();
        test_identity_clean();
        test_identity_errors();
        test_ksa_perm();
        test_perm_duplicate();
        test_start_ignored_and_restart();
        test_reset_mid_sweep();
        test_random();
        test_write_enable();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
